// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // Digit word fields: [5]=en, [4]=dp, [3:0]=hex
  localparam int unsigned EN_BIT  = 5;
  localparam int unsigned DP_BIT  = 4;
  localparam int unsigned HEX_MSB = 3;

  // All segments / anodes off (active-low)
  localparam logic [7:0] SSEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns for hex 0..F
  localparam logic [6:0] HEX_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex + decimal point to active-low {dp,g,f,e,d,c,b,a}.
import sseg_pkg::*;

module hex_to_sseg (
  input  logic [HEX_MSB:0] hex,
  input  logic             dp,
  output logic [7:0]       seg_c
);

  // dp=1 lights the point, so it is inverted into the active-low MSB
  always_comb begin
    seg_c = {~dp, HEX_LUT[hex]};
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with a blanking
// gap between digits. Optional brightness control under SSEG_DIM_EN.
import sseg_pkg::*;

module sseg_scan_ctrl #(
  parameter int unsigned BITS         = 6,
  parameter int unsigned REFRESH_DIV  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic            clk,
  input  logic            reset,
`ifdef SSEG_DIM_EN
  input  logic [2:0]      dim,
`endif
  input  logic [BITS-1:0] digit_in,
  output logic [2:0]      sel,
  output logic [7:0]      an,
  output logic [7:0]      sseg,
  output logic            frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);

  // Reject parameter sets that leave no blanking or no display time
  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV || BITS < 6) begin : g_bad_params
    $error("sseg_scan_ctrl: need 1 <= BLANK_CYCLES < REFRESH_DIV and BITS >= 6");
  end

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [BITS-1:0]   digit_q;
  logic [7:0]        seg_c;
  logic              lit_c;

  hex_to_sseg u_hex_to_sseg (
    .hex   (digit_q[HEX_MSB:0]),
    .dp    (digit_q[DP_BIT]),
    .seg_c (seg_c)
  );

`ifdef SSEG_DIM_EN
  logic [2:0] pwm;

  // Free-running duty-cycle counter for brightness control
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm <= 3'd0;
    else       pwm <= pwm + 3'd1;
  end

  // Anode enabled only during the upper part of the pwm period
  always_comb begin
    lit_c = digit_q[EN_BIT] && (pwm >= dim);
  end
`else
  // Full duty: anode follows the enable bit only
  always_comb begin
    lit_c = digit_q[EN_BIT];
  end
`endif

  // Scan FSM: blank gap, capture mux word, show it, advance digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      cnt        <= '0;
      sel        <= 3'd0;
      digit_q    <= '0;
      an         <= SSEG_BLANK;
      sseg       <= SSEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      case (state)
        BLANK: begin
          an   <= SSEG_BLANK;
          sseg <= SSEG_BLANK;
          if (cnt == BLANK_LAST) begin
            cnt     <= '0;
            digit_q <= digit_in;
            state   <= SHOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          sseg <= seg_c;
          an   <= lit_c ? ~(8'h01 << sel) : SSEG_BLANK;
          if (cnt == SHOW_LAST) begin
            cnt        <= '0;
            sel        <= sel + 3'd1;
            frame_tick <= (sel == 3'd7);
            state      <= BLANK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (REFRESH_DIV=10, BLANK_CYCLES=2).
// Build with SSEG_DIM_EN defined to also exercise brightness control.
module tb_sseg_scan_ctrl;

  localparam int unsigned REFRESH_DIV  = 10;
  localparam int unsigned BLANK_CYCLES = 2;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] an;
    logic [7:0] sseg;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] digit_in = 6'd0;
  logic [2:0] sel;
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;
`ifdef SSEG_DIM_EN
  logic [2:0] dim = 3'd0;
`endif

  int         tests = 0;
  int         fails = 0;
  int         n = 0;
  bit         mux_on = 1'b1;
  logic [5:0] digits [8];
  exp_t       sb [$];

  sseg_scan_ctrl #(
    .BITS         (6),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef SSEG_DIM_EN
    .dim        (dim),
`endif
    .digit_in   (digit_in),
    .sel        (sel),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference segment pattern, active-low {dp,g..a}
  function automatic logic [7:0] ref_seg(input logic [5:0] w);
    logic [7:0] s;
    case (w[3:0])
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    if (w[4]) s[7] = 1'b0;
    return s;
  endfunction

  // Reference anode pattern for digit k
  function automatic logic [7:0] ref_an(input int k, input logic en);
    logic [7:0] a;
    case (k % 8)
      0: a = 8'hFE; 1: a = 8'hFD; 2: a = 8'hFB; 3: a = 8'hF7;
      4: a = 8'hEF; 5: a = 8'hDF; 6: a = 8'hBF; default: a = 8'h7F;
    endcase
    return en ? a : 8'hFF;
  endfunction

  // One clock, then sample point on the falling edge; mux follows sel
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    if (mux_on) digit_in = digits[sel];
  endtask

  // Hold reset for 5 cycles and release on a falling edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    if (mux_on) digit_in = digits[sel];
  endtask

  task automatic test_reset();
    mux_on = 1'b1;
    digits[0] = 6'b10_0011;
    do_reset();
    for (int i = 0; i <= 3; i++) begin
      if (i > 0) step();
      tests++;
      if (i < 3) begin
        if (an !== 8'hFF || sseg !== 8'hFF || sel !== 3'd0 || frame_tick !== 1'b0) begin
          fails++;
          $display("FAIL reset_idle cyc=%0d an=%h sseg=%h sel=%0d ft=%b, want FF FF 0 0",
                   i, an, sseg, sel, frame_tick);
        end
      end else begin
        if (an !== 8'hFE || sseg !== 8'hB0 || sel !== 3'd0) begin
          fails++;
          $display("FAIL reset_first_lit an=%h sseg=%h sel=%0d, want FE B0 0", an, sseg, sel);
        end
      end
    end
  endtask

  task automatic test_digits();
    exp_t       e;
    logic [7:0] w_an, w_seg;
    logic [2:0] w_sel;
    mux_on = 1'b1;
    digits[0] = 6'b10_0011;
    digits[1] = 6'b11_0000;
    digits[2] = 6'b00_0101;
    digits[3] = 6'b10_1010;
    digits[4] = 6'b10_1111;
    digits[5] = 6'b11_1000;
    digits[6] = 6'b10_1101;
    digits[7] = 6'b10_0110;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      e.sel  = 3'(k % 8);
      e.an   = ref_an(k, digits[k % 8][5]);
      e.sseg = ref_seg(digits[k % 8]);
      sb.push_back(e);
    end
    for (int k = 0; k < 9; k++) begin
      e = sb.pop_front();
      for (int j = 1; j <= 10; j++) begin
        step();
        w_an  = (j <= 2) ? 8'hFF : e.an;
        w_seg = (j <= 2) ? 8'hFF : e.sseg;
        w_sel = (j == 10) ? e.sel + 3'd1 : e.sel;
        tests++;
        if (an !== w_an || sseg !== w_seg || sel !== w_sel) begin
          fails++;
          $display("FAIL digits slot=%0d j=%0d an=%h/%h sseg=%h/%h sel=%0d/%0d (got/want)",
                   k, j, an, w_an, sseg, w_seg, sel, w_sel);
        end
      end
    end
  endtask

  // digit_in changing during SHOW must not reach the display until recapture
  task automatic test_back_to_back();
    exp_t       e;
    logic [7:0] w_an, w_seg;
    mux_on = 1'b0;
    digit_in = 6'b10_0001;
    do_reset();
    e.sel = 3'd0; e.an = 8'hFE; e.sseg = 8'hF9; sb.push_back(e);
    e.sel = 3'd1; e.an = 8'hFD; e.sseg = 8'h80; sb.push_back(e);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      for (int j = 1; j <= 10; j++) begin
        step();
        if (n == 2) digit_in = 6'b10_1000;
        w_an  = (j <= 2) ? 8'hFF : e.an;
        w_seg = (j <= 2) ? 8'hFF : e.sseg;
        tests++;
        if (an !== w_an || sseg !== w_seg) begin
          fails++;
          $display("FAIL hold_capture slot=%0d j=%0d an=%h/%h sseg=%h/%h (got/want)",
                   k, j, an, w_an, sseg, w_seg);
        end
      end
    end
    mux_on = 1'b1;
  endtask

  task automatic test_free_run();
    int ticks;
    logic [2:0] w_sel;
    logic       w_ft;
    ticks = 0;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step();
      w_sel = 3'((n / 10) % 8);
      w_ft  = (n % 80 == 0);
      if (frame_tick === 1'b1) ticks++;
      tests++;
      if (sel !== w_sel || frame_tick !== w_ft) begin
        fails++;
        $display("FAIL free_run n=%0d sel=%0d/%0d ft=%b/%b (got/want)",
                 n, sel, w_sel, frame_tick, w_ft);
      end
    end
    tests++;
    if (ticks != 2) begin
      fails++;
      $display("FAIL frame_tick_count got=%0d want=2", ticks);
    end
  endtask

  task automatic test_async_reset();
    mux_on = 1'b1;
    digits[0] = 6'b10_0011;
    digits[3] = 6'b10_1010;
    do_reset();
    repeat (35) step();
    tests++;
    if (an !== 8'hF7 || sseg !== 8'h88 || sel !== 3'd3) begin
      fails++;
      $display("FAIL pre_reset an=%h sseg=%h sel=%0d, want F7 88 3", an, sseg, sel);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (an !== 8'hFF || sseg !== 8'hFF || sel !== 3'd0 || frame_tick !== 1'b0) begin
      fails++;
      $display("FAIL async_reset an=%h sseg=%h sel=%0d ft=%b, want FF FF 0 0",
               an, sseg, sel, frame_tick);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n = 0;
    digit_in = digits[sel];
    for (int j = 1; j <= 3; j++) begin
      step();
      tests++;
      if (j < 3) begin
        if (an !== 8'hFF || sseg !== 8'hFF || sel !== 3'd0) begin
          fails++;
          $display("FAIL resume_blank j=%0d an=%h sseg=%h sel=%0d, want FF FF 0", j, an, sseg, sel);
        end
      end else begin
        if (an !== 8'hFE || sseg !== 8'hB0 || sel !== 3'd0) begin
          fails++;
          $display("FAIL resume_show an=%h sseg=%h sel=%0d, want FE B0 0", an, sseg, sel);
        end
      end
    end
  endtask

`ifdef SSEG_DIM_EN
  task automatic test_dim();
    int lit;
    logic [2:0] levels [2];
    int         want [2];
    levels[0] = 3'd4; want[0] = 4;
    levels[1] = 3'd0; want[1] = 8;
    mux_on = 1'b1;
    digits[0] = 6'b10_0011;
    for (int t = 0; t < 2; t++) begin
      dim = levels[t];
      do_reset();
      lit = 0;
      for (int j = 1; j <= 10; j++) begin
        step();
        if (j >= 3 && an === 8'hFE) lit++;
      end
      tests++;
      if (lit != want[t]) begin
        fails++;
        $display("FAIL dim level=%0d lit_cycles=%0d want=%0d", levels[t], lit, want[t]);
      end
    end
    dim = 3'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_digits();
    test_back_to_back();
    test_free_run();
    test_async_reset();
`ifdef SSEG_DIM_EN
    test_dim();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
